// File: rtl/core_run_pkg.sv
// Shared types for the core run/halt sequencer.
package core_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        HS_NONE    = 2'd0,
        HS_ZERO    = 2'd1,
        HS_PC      = 2'd2,
        HS_TIMEOUT = 2'd3
    } halt_status_t;

endpackage

// File: rtl/core_run_controller_halt_detector.sv
// Halt condition detector: consecutive-zero counter plus PC sentinel and timeout compares.
module halt_detector
    import core_run_pkg::*;
#(
    parameter int              PC_W       = 8,
    parameter int              INSTR_W    = 9,
    parameter int              CNT_W      = 16,
    parameter int              HALT_ZEROS = 1,
    parameter logic [PC_W-1:0] HALT_PC    = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               launch,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] mach_code,
    input  logic [CNT_W-1:0]   timeout_limit,
    input  logic [CNT_W-1:0]   cycle_count,
    output logic               halt_now,
    output halt_status_t       status
);

    localparam int ZC_W = $clog2(HALT_ZEROS) + 1;
    localparam logic [ZC_W-1:0] ZC_LAST = ZC_W'(HALT_ZEROS - 1);

    logic [ZC_W-1:0] zcnt;
    logic            instr_zero;
    logic            zero_hit;
    logic            pc_hit;
    logic            to_hit;

    assign instr_zero = (mach_code == '0);
    assign zero_hit   = instr_zero && (zcnt == ZC_LAST);
    assign pc_hit     = (pc == HALT_PC);
    assign to_hit     = (timeout_limit != '0) && (cycle_count == timeout_limit);
    assign halt_now   = run && (zero_hit || pc_hit || to_hit);

    always_comb begin
        status = HS_NONE;
        if (zero_hit) begin
            status = HS_ZERO;
        end else if (pc_hit) begin
            status = HS_PC;
        end else if (to_hit) begin
            status = HS_TIMEOUT;
        end
    end

    // Counter freezes on the halt cycle, so it never passes ZC_LAST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zcnt <= '0;
        end else if (launch) begin
            zcnt <= '0;
        end else if (run && !halt_now) begin
            zcnt <= instr_zero ? zcnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/core_run_controller.sv
// Run/halt sequencer beside the core: launches on start edge, gates commits, reports halt cause.
module core_run_controller
    import core_run_pkg::*;
#(
    parameter int              PC_W       = 8,
    parameter int              INSTR_W    = 9,
    parameter int              CNT_W      = 16,
    parameter int              HALT_ZEROS = 1,
    parameter logic [PC_W-1:0] HALT_PC    = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] mach_code,
    input  logic [CNT_W-1:0]   timeout_limit,
    output logic               core_clear,
    output logic               core_run,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [PC_W-1:0]    halt_pc,
    output logic [CNT_W-1:0]   cycle_count
);

    run_state_t   state;
    run_state_t   state_nxt;
    halt_status_t status_q;
    halt_status_t hit_status;
    logic         start_q;
    logic         launch;
    logic         running;
    logic         halt_now;

    assign launch  = start && !start_q && ((state == ST_IDLE) || (state == ST_DONE));
    assign running = (state == ST_RUN);

    halt_detector #(
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .CNT_W      (CNT_W),
        .HALT_ZEROS (HALT_ZEROS),
        .HALT_PC    (HALT_PC)
    ) u_halt_detector (
        .clk           (clk),
        .reset         (reset),
        .run           (running),
        .launch        (launch),
        .pc            (pc),
        .mach_code     (mach_code),
        .timeout_limit (timeout_limit),
        .cycle_count   (cycle_count),
        .halt_now      (halt_now),
        .status        (hit_status)
    );

    // Edge detector keeps tracking while busy so a held start never relaunches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (launch) state_nxt = ST_CLEAR;
            ST_CLEAR:         state_nxt = ST_RUN;
            ST_RUN:           if (halt_now) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    assign core_clear = (state == ST_CLEAR);
    assign core_run   = running && !halt_now;
    assign busy       = (state == ST_CLEAR) || (state == ST_RUN);
    assign done       = (state == ST_DONE);
    assign status     = status_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            halt_pc     <= '0;
            status_q    <= HS_NONE;
        end else if (launch) begin
            cycle_count <= '0;
            halt_pc     <= '0;
            status_q    <= HS_NONE;
        end else if (running) begin
            if (halt_now) begin
                halt_pc  <= pc;
                status_q <= hit_status;
            end else if (cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

endmodule
